sort_4_serial: RTL and testbench
================================

SORT_4_SERIAL -- requirements
Module: sort_4_serial

Interface
REQ-001 SHALL have parameter: W, 4, bit width of one element.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  in_data holds an element.
REQ-005 SHALL have port: in_ready  output  1  block accepts an element this cycle.
REQ-006 SHALL have port: in_data  input  W  unsigned element.
REQ-007 SHALL have port: out_valid  output  1  out_data holds a sorted group.
REQ-008 SHALL have port: out_ready  input  1  consumer takes out_data this cycle.
REQ-009 SHALL have port: out_data  output  4*W  sorted group, slot 3 = [4W-1:3W] ... slot 0 = [W-1:0].

Function
REQ-010 SHALL collect four serially delivered elements into registers r0..r3, in arrival order, then emit them as one packed word sorted by unsigned value.
REQ-011 SHALL implement FSM states LOAD, SORT, OUT; LOAD->SORT on acceptance of 4th element; SORT->OUT after step 4; OUT->LOAD on out_valid && out_ready.
REQ-012 SHALL accept an element on a rising edge where in_valid && in_ready; in_ready = 1 only in LOAD, independent of in_valid.
REQ-013 SHALL keep a 2-bit fill counter cleared on entry to LOAD; element n (0..3) written to r[n]; counter does not advance without a handshake.
REQ-014 SHALL perform exactly one compare-exchange per SORT cycle, steps 0..4: (r0,r1), (r2,r3), (r0,r2), (r1,r3), (r1,r2); after each step the first-named register holds the larger value.
REQ-015 SHALL treat equal values as no-swap-needed; either result is acceptable since values are identical.
REQ-016 SHALL assert out_valid exactly 5 cycles after the edge accepting the 4th element, i.e. in the cycle after the 5th SORT edge.
REQ-017 SHALL drive out_data = {r0,r1,r2,r3} (largest in slot 3) and hold out_data and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL deassert out_valid on the edge where out_ready is sampled high and assert in_ready in the following cycle; no overlap of loading and output.
REQ-019 SHALL ignore in_valid/in_data during SORT and OUT; SHALL ignore out_ready when out_valid = 0.
REQ-020 SHALL support full-rate back-to-back groups: minimum period 4 + 5 + 1 = 10 cycles per group with out_ready held high.

Reset
REQ-021 SHALL on rst = 1 immediately force state LOAD, counter 0, step 0, r0..r3 = 0, out_valid = 0, in_ready = 1 (after release), out_data = 0.
REQ-022 SHALL discard any partial group or pending output when reset asserts mid-operation; no element accepted while rst = 1.

Configuration
REQ-023 SHALL, with SORT_4_SERIAL_ASCENDING_EN undefined, output descending order per REQ-017.
REQ-024 SHALL, with SORT_4_SERIAL_ASCENDING_EN defined, output ascending order (smallest in slot 3, largest in slot 0) with identical latency and handshake timing.

Structure
REQ-025 SHALL take from shared package sort_pkg: default element width constant, state enum (LOAD, SORT, OUT), number of sort steps (5).
REQ-026 SHALL instantiate one combinational sub-module sort_cmp_swap (inputs a,b; outputs hi,lo) reused for all five steps via operand muxing.

Verification
REQ-027 SHALL verify: rst released, feed 3,9,1,7 with out_ready = 1 -> out_data = 0x9731, out_valid high exactly 5 cycles after 4th accept.
REQ-028 SHALL verify: feed 5,5,2,5 -> out_data = 0x5552; ties produce no corruption.
REQ-029 SHALL verify: feed F,0,F,0 with in_valid toggling every other cycle -> only handshaked values stored, out_data = 0xFF00.
REQ-030 SHALL verify: out_ready = 0 for 7 cycles after out_valid -> out_data/out_valid stable, in_ready = 0, then release -> in_ready = 1 next cycle.
REQ-031 SHALL verify: rst pulsed after 2 elements, then feed 1,2,3,4 -> out_data = 0x4321, no stale data.
REQ-032 SHALL verify: with SORT_4_SERIAL_ASCENDING_EN defined, feed 3,9,1,7 -> out_data = 0x1379, same latency.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants and types for the serial 4-element sorter.
// Step table maps each sort step to the register pair it compares.
package sort_pkg;

  localparam int ELEM_W     = 4;
  localparam int SORT_STEPS = 5;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Returns {first, second} register index for one step.
  function automatic logic [3:0] step_pair(
    input logic [2:0] s
  );
    logic [3:0] p;
    p = 4'b0001;
    unique case (s)
      3'd0:    p = {2'd0, 2'd1};
      3'd1:    p = {2'd2, 2'd3};
      3'd2:    p = {2'd0, 2'd2};
      3'd3:    p = {2'd1, 2'd3};
      3'd4:    p = {2'd1, 2'd2};
      default: p = {2'd0, 2'd1};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange: hi gets the larger operand.
// Equal operands pass through unswapped.
module sort_cmp_swap
  import sort_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  logic ge;

  assign ge = (a >= b);
  assign hi = ge ? a : b;
  assign lo = ge ? b : a;

endmodule

// File: rtl/sort_4_serial.sv
// Serial 4-element sorter: load four, five compare-exchange steps, emit.
// Define SORT_4_SERIAL_ASCENDING_EN for ascending output order.
module sort_4_serial
  import sort_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_data
);

  state_t       state;
  logic [1:0]   cnt;
  logic [2:0]   step;
  logic [W-1:0] r [4];

  logic [3:0]   pair;
  logic [1:0]   ia;
  logic [1:0]   ib;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] first;
  logic [W-1:0] second;

  assign pair = step_pair(step);
  assign ia   = pair[3:2];
  assign ib   = pair[1:0];

  sort_cmp_swap #(.W(W)) u_cmp (
    .a  (r[ia]),
    .b  (r[ib]),
    .hi (hi),
    .lo (lo)
  );

  // Direction only changes which register of the pair keeps the max.
`ifdef SORT_4_SERIAL_ASCENDING_EN
  assign first  = lo;
  assign second = hi;
`else
  assign first  = hi;
  assign second = lo;
`endif

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign out_data  = {r[0], r[1], r[2], r[3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= 2'd0;
      step  <= 3'd0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            r[cnt] <= in_data;
            cnt    <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state <= SORT;
              step  <= 3'd0;
            end
          end
        end
        SORT: begin
          r[ia] <= first;
          r[ib] <= second;
          if (step == 3'(SORT_STEPS - 1)) begin
            state <= OUT;
          end else begin
            step <= step + 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state <= LOAD;
            cnt   <= 2'd0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_4_serial.sv
// Self-checking bench for sort_4_serial with a reference-sort scoreboard.
// Honors SORT_4_SERIAL_ASCENDING_EN for expected ordering.
module tb_sort_4_serial;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [3:0]  in_data = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int rise_cyc = 0;
  logic [15:0] sb [$];

  sort_4_serial #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_sort(
    input logic [3:0] a, b, c, d
  );
    logic [3:0] v [4];
    logic [3:0] t;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3 - i; j++)
`ifdef SORT_4_SERIAL_ASCENDING_EN
        if (v[j] > v[j+1]) begin
`else
        if (v[j] < v[j+1]) begin
`endif
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic send(input logic [3:0] v);
    int n = 0;
    in_valid = 1;
    in_data  = v;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL send_timeout got in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 0;
    in_data  = 4'hA;
  endtask

  task automatic send_group(
    input logic [3:0] a, b, c, d, input bit gaps
  );
    logic [3:0] e [4];
    e[0] = a; e[1] = b; e[2] = c; e[3] = d;
    sb.push_back(ref_sort(a, b, c, d));
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 0;
        in_data  = ~e[i];
        @(posedge clk);
        #1;
      end
      send(e[i]);
    end
  endtask

  task automatic wait_out(input int lat);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    rise_cyc = cyc;
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL out_timeout got out_valid=0 want 1");
    end
    if (lat > 0) begin
      total++;
      if (cyc - acc_cyc !== lat) begin
        bad++;
        $display("FAIL latency got %0d want %0d",
                 cyc - acc_cyc, lat);
      end
    end
  endtask

  task automatic take(input string nm);
    logic [15:0] exp;
    exp = sb.size() > 0 ? sb.pop_front() : 16'hxxxx;
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", nm, out_data, exp);
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 0 || in_ready !== 1) begin
      bad++;
      $display("FAIL %s_hs got ov=%b ir=%b want 0 1",
               nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (out_valid !== 0 || out_data !== 0) begin
      bad++;
      $display("FAIL reset got ov=%b od=%h want 0 0000",
               out_valid, out_data);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    total++;
    if (in_ready !== 1) begin
      bad++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic [15:0] k;
`ifdef SORT_4_SERIAL_ASCENDING_EN
    k = 16'h1379;
`else
    k = 16'h9731;
`endif
    out_ready = 1;
    send_group(4'h3, 4'h9, 4'h1, 4'h7, 0);
    in_valid = 1;
    in_data  = 4'hF;
    wait_out(5);
    in_valid = 0;
    total++;
    if (out_data !== k) begin
      bad++;
      $display("FAIL basic_const got %h want %h", out_data, k);
    end
    take("basic");
  endtask

  task automatic test_ties;
    out_ready = 1;
    send_group(4'h5, 4'h5, 4'h2, 4'h5, 0);
    wait_out(5);
    take("ties");
  endtask

  task automatic test_gaps;
    out_ready = 1;
    send_group(4'hF, 4'h0, 4'hF, 4'h0, 1);
    wait_out(5);
    take("gaps");
  endtask

  task automatic test_backpressure;
    logic [15:0] exp;
    out_ready = 0;
    send_group(4'h2, 4'hC, 4'h8, 4'h4, 0);
    wait_out(5);
    exp = sb[0];
    for (int i = 0; i < 7; i++) begin
      in_valid = 1;
      in_data  = 4'(i);
      @(negedge clk);
      total++;
      if (out_valid !== 1 || in_ready !== 0 ||
          out_data !== exp) begin
        bad++;
        $display("FAIL hold%0d got ov=%b ir=%b od=%h want 1 0 %h",
                 i, out_valid, in_ready, out_data, exp);
      end
    end
    in_valid = 0;
    take("bp");
  endtask

  task automatic test_reset_mid;
    out_ready = 1;
    send(4'hE);
    send(4'hD);
    rst = 1;
    in_valid = 1;
    in_data  = 4'hF;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_data !== 0 || out_valid !== 0) begin
      bad++;
      $display("FAIL mid_rst got od=%h ov=%b want 0000 0",
               out_data, out_valid);
    end
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    send_group(4'h1, 4'h2, 4'h3, 4'h4, 0);
    wait_out(5);
    take("rst_mid");
  endtask

  task automatic test_back_to_back;
    int prev;
    out_ready = 1;
    send_group(4'h6, 4'hB, 4'h0, 4'h9, 0);
    wait_out(5);
    prev = rise_cyc;
    take("b2b0");
    for (int g = 1; g < 4; g++) begin
      send_group(4'($urandom_range(15)),
                 4'($urandom_range(15)),
                 4'($urandom_range(15)),
                 4'($urandom_range(15)), 0);
      wait_out(5);
      total++;
      if (rise_cyc - prev !== 10) begin
        bad++;
        $display("FAIL period got %0d want 10", rise_cyc - prev);
      end
      prev = rise_cyc;
      take("b2b");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ties;
    test_gaps;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
